// File: rtl/speed_sequencer.sv
// Speed register and display driver for the car: offset-encoded speed (27 = stopped),
// tick-divided driver sampling, braking/saturation rules and pause blanking.
// Optional macro COAST_EN: idle ticks drift the speed one code toward 27.
`timescale 1ns/1ps
module speed_sequencer #(
    parameter int TICK_DIV   = 1000000,
    parameter int BRAKE_STEP = 2
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Accelerate,
    input  logic       Brake,
    input  logic       GearReverse,
    input  logic       Pause,
    output logic [6:0] Speed,
    output logic       DisplayEnable,
    output logic       Direction,
    output logic       Moving
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [7:0] BRAKE_AMT  = 8'(BRAKE_STEP);
    localparam logic [6:0] SPEED_STOP = 7'd27;
    localparam logic [6:0] SPEED_MAX  = 7'd127;
    localparam logic [6:0] SPEED_MIN  = 7'd0;

    localparam logic [1:0] ST_STOPPED = 2'd0;
    localparam logic [1:0] ST_FORWARD = 2'd1;
    localparam logic [1:0] ST_REVERSE = 2'd2;
    localparam logic [1:0] ST_PAUSED  = 2'd3;

    // Sums are formed 8 bits wide so the 7-bit speed can never wrap past its limit.
    function automatic logic [6:0] sat_add(input logic [6:0] spd, input logic [7:0] amt,
                                           input logic [6:0] ceil_v);
        logic [7:0] sum_v;
        sum_v = {1'b0, spd} + amt;
        if (sum_v > {1'b0, ceil_v}) begin
            sat_add = ceil_v;
        end else begin
            sat_add = sum_v[6:0];
        end
    endfunction

    function automatic logic [6:0] sat_sub(input logic [6:0] spd, input logic [7:0] amt,
                                           input logic [6:0] floor_v);
        logic [7:0] lim_v;
        logic [7:0] diff_v;
        lim_v  = {1'b0, floor_v} + amt;
        diff_v = {1'b0, spd} - amt;
        if ({1'b0, spd} < lim_v) begin
            sat_sub = floor_v;
        end else begin
            sat_sub = diff_v[6:0];
        end
    endfunction

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [1:0]       ret_r;
    logic [1:0]       ret_nxt_s;
    logic [6:0]       speed_r;
    logic [6:0]       speed_nxt_s;
    logic [1:0]       upd_state_s;
    logic [6:0]       upd_speed_s;
    logic             tick_s;
    logic             den_r;
    logic             dir_r;
    logic             moving_r;
    logic             dir_nxt_s;

    assign tick_s = (cnt_r == TICK_LAST) && (state_r != ST_PAUSED);

    // Speed and state a tick would produce from the current driver inputs
    always_comb begin
        upd_speed_s = speed_r;
        upd_state_s = state_r;
        case (state_r)
            ST_STOPPED: begin
                if (Accelerate && !Brake) begin
                    if (GearReverse) begin
                        upd_speed_s = 7'd26;
                        upd_state_s = ST_REVERSE;
                    end else begin
                        upd_speed_s = 7'd28;
                        upd_state_s = ST_FORWARD;
                    end
                end else begin
                    upd_speed_s = speed_r;
                    upd_state_s = ST_STOPPED;
                end
            end
            ST_FORWARD: begin
                if (Brake) begin
                    upd_speed_s = sat_sub(speed_r, BRAKE_AMT, SPEED_STOP);
                end else if (Accelerate) begin
                    upd_speed_s = sat_add(speed_r, 8'd1, SPEED_MAX);
                end else begin
`ifdef COAST_EN
                    upd_speed_s = sat_sub(speed_r, 8'd1, SPEED_STOP);
`else
                    upd_speed_s = speed_r;
`endif
                end
                if (upd_speed_s == SPEED_STOP) begin
                    upd_state_s = ST_STOPPED;
                end else begin
                    upd_state_s = ST_FORWARD;
                end
            end
            ST_REVERSE: begin
                if (Brake) begin
                    upd_speed_s = sat_add(speed_r, BRAKE_AMT, SPEED_STOP);
                end else if (Accelerate) begin
                    upd_speed_s = sat_sub(speed_r, 8'd1, SPEED_MIN);
                end else begin
`ifdef COAST_EN
                    upd_speed_s = sat_add(speed_r, 8'd1, SPEED_STOP);
`else
                    upd_speed_s = speed_r;
`endif
                end
                if (upd_speed_s == SPEED_STOP) begin
                    upd_state_s = ST_STOPPED;
                end else begin
                    upd_state_s = ST_REVERSE;
                end
            end
            default: begin
                upd_speed_s = speed_r;
                upd_state_s = state_r;
            end
        endcase
    end

    // Pause has priority over any tick; the return register records where to resume
    always_comb begin
        state_nxt_s = state_r;
        ret_nxt_s   = ret_r;
        speed_nxt_s = speed_r;
        case (state_r)
            ST_PAUSED: begin
                if (Pause) begin
                    state_nxt_s = ST_PAUSED;
                end else begin
                    state_nxt_s = ret_r;
                end
            end
            ST_STOPPED, ST_FORWARD, ST_REVERSE: begin
                if (Pause) begin
                    state_nxt_s = ST_PAUSED;
                    ret_nxt_s   = state_r;
                end else if (tick_s) begin
                    state_nxt_s = upd_state_s;
                    speed_nxt_s = upd_speed_s;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_STOPPED;
                ret_nxt_s   = ST_STOPPED;
                speed_nxt_s = SPEED_STOP;
            end
        endcase
    end

    // Holding the counter at 0 through the exit edge gives a full interval before the next tick
    always_comb begin
        if ((state_nxt_s == ST_PAUSED) || (state_r == ST_PAUSED)) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (tick_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Reverse is shown while paused if that is where the car will resume
    always_comb begin
        if (state_nxt_s == ST_REVERSE) begin
            dir_nxt_s = 1'b1;
        end else if ((state_nxt_s == ST_PAUSED) && (ret_nxt_s == ST_REVERSE)) begin
            dir_nxt_s = 1'b1;
        end else begin
            dir_nxt_s = 1'b0;
        end
    end

    // Core state: FSM, return state, speed and tick counter
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r <= ST_STOPPED;
            ret_r   <= ST_STOPPED;
            speed_r <= SPEED_STOP;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ret_r   <= ret_nxt_s;
            speed_r <= speed_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Display-side status flags, registered from the next-state values
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            den_r    <= 1'b1;
            dir_r    <= 1'b0;
            moving_r <= 1'b0;
        end else begin
            den_r    <= (state_nxt_s != ST_PAUSED);
            dir_r    <= dir_nxt_s;
            moving_r <= (speed_nxt_s != SPEED_STOP);
        end
    end

    assign Speed         = speed_r;
    assign DisplayEnable = den_r;
    assign Direction     = dir_r;
    assign Moving        = moving_r;

endmodule

// File: tb/tb_speed_sequencer.sv
// Directed bench for speed_sequencer with TICK_DIV=4, BRAKE_STEP=2.
// Expectations for idle ticks follow the COAST_EN macro.
`timescale 1ns/1ps
module tb_speed_sequencer;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       Accelerate;
    logic       Brake;
    logic       GearReverse;
    logic       Pause;
    logic [6:0] Speed;
    logic       DisplayEnable;
    logic       Direction;
    logic       Moving;

    int checks   = 0;
    int failures = 0;

`ifdef COAST_EN
    localparam bit COAST = 1'b1;
`else
    localparam bit COAST = 1'b0;
`endif

    typedef struct {
        logic acc;
        logic brk;
        logic gear;
        logic pse;
        int   ncyc;
        int   spd;
        int   den;
        int   dir;
        int   mov;
    } vec_t;

    vec_t vecs [15];

    speed_sequencer #(.TICK_DIV(4), .BRAKE_STEP(2)) dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .Accelerate   (Accelerate),
        .Brake        (Brake),
        .GearReverse  (GearReverse),
        .Pause        (Pause),
        .Speed        (Speed),
        .DisplayEnable(DisplayEnable),
        .Direction    (Direction),
        .Moving       (Moving)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    task automatic chk_out(input string nm, input int spd, input int den, input int dir, input int mov);
        chk({nm, ".speed"}, int'(Speed), spd);
        chk({nm, ".den"}, int'(DisplayEnable), den);
        chk({nm, ".dir"}, int'(Direction), dir);
        chk({nm, ".moving"}, int'(Moving), mov);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic drive(input logic a, input logic b, input logic g, input logic p);
        Accelerate  = a;
        Brake       = b;
        GearReverse = g;
        Pause       = p;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Resetn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(2);
        Resetn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int want;
        Resetn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        //           acc   brk   gear  pse  cyc spd den dir mov
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 27, 1, 0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 28, 1, 0, 1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4, 29, 1, 0, 1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4, 30, 1, 0, 1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4, 28, 1, 0, 1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4, 27, 1, 0, 0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4, 27, 1, 0, 0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4, 27, 1, 0, 0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4, 26, 1, 1, 1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4, 25, 1, 1, 1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 4, 27, 1, 0, 0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 4, 26, 1, 1, 1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 4, 27, 1, 0, 0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 4, 28, 1, 0, 1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 4, 27, 1, 0, 0};

        cyc(1);
        chk_out("reset", 27, 1, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(2);
        chk_out("reset_hold", 27, 1, 0, 0);
        Resetn = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].acc, vecs[i].brk, vecs[i].gear, vecs[i].pse);
            cyc(vecs[i].ncyc);
            chk_out($sformatf("vec%0d", i), vecs[i].spd, vecs[i].den, vecs[i].dir, vecs[i].mov);
        end

        // pause while reversing keeps Direction and holds the counter
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(4);
        chk_out("rev_go", 26, 1, 1, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1);
        chk_out("rev_pause", 26, 0, 1, 1);
        cyc(4);
        chk_out("rev_pause_hold", 26, 0, 1, 1);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1);
        chk_out("rev_resume", 26, 1, 1, 1);
        cyc(3);
        chk_out("rev_resume_wait", 26, 1, 1, 1);
        cyc(1);
        chk_out("rev_brake_clamp", 27, 1, 0, 0);

        // forward saturation, then brake all the way down
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4 * 99);
        chk_out("fwd_126", 126, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(4);
            chk_out($sformatf("fwd_sat%0d", i), 127, 1, 0, 1);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(4 * 49);
        chk_out("fwd_brake_29", 29, 1, 0, 1);
        cyc(4);
        chk_out("fwd_brake_27", 27, 1, 0, 0);

        // reverse saturation at code 0, then brake back to stop
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(4);
        chk_out("rev_26", 26, 1, 1, 1);
        cyc(4 * 26);
        chk_out("rev_0", 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(4);
            chk_out($sformatf("rev_sat%0d", i), 0, 1, 1, 1);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(4 * 13);
        chk_out("rev_brake_26", 26, 1, 1, 1);
        cyc(4);
        chk_out("rev_brake_27", 27, 1, 0, 0);

        // pause at speed 40 across two tick points, resume timing, pause on a tick edge
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4 * 13);
        chk_out("fwd_40", 40, 1, 0, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk_out($sformatf("pause%0d", i), 40, 0, 0, 1);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1);
        chk_out("resume", 40, 1, 0, 1);
        cyc(3);
        chk_out("resume_wait", 40, 1, 0, 1);
        cyc(1);
        chk_out("resume_tick", 41, 1, 0, 1);
        cyc(3);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1);
        chk_out("pause_on_tick", 41, 0, 0, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1);
        chk_out("resume2", 41, 1, 0, 1);
        cyc(3);
        chk_out("resume2_wait", 41, 1, 0, 1);
        cyc(1);
        chk_out("resume2_tick", 42, 1, 0, 1);

        // reset pulse in the middle of braking
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4 * 35);
        chk_out("fwd_62", 62, 1, 0, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(4);
        chk_out("brake_60", 60, 1, 0, 1);
        cyc(2);
        Resetn = 1'b0;
        #1;
        chk_out("midbrake_reset", 27, 1, 0, 0);
        @(negedge Clock);
        Resetn = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(3);
        chk_out("post_reset_wait", 27, 1, 0, 0);
        cyc(1);
        chk_out("post_reset_tick", 28, 1, 0, 1);

        // idle ticks at speed 30
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(12);
        chk_out("coast_start", 30, 1, 0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            cyc(4);
            want = COAST ? (30 - k) : 30;
            chk_out($sformatf("idle%0d", k), want, 1, 0, (want != 27) ? 1 : 0);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(4);
        if (COAST) begin
            chk_out("idle_then_rev", 26, 1, 1, 1);
        end else begin
            chk_out("idle_then_rev", 31, 1, 0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
